// File: rtl/scroll_addr_seq_pkg.sv
// Shared definitions for the scroll address sequencer and the LED font ROM.
//   state_t            : sequencer FSM state encoding
//   DEF_AW             : default font ROM address width
//   DEF_ADDR_MIN/MAX   : default scroll window, shared with the font ROM so
//                        window edits stay consistent on both sides
package scroll_addr_seq_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int DEF_AW       = 5;
  localparam int DEF_ADDR_MIN = 0;
  localparam int DEF_ADDR_MAX = 31;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton debouncer: 2-FF synchronizer followed by a stability counter.
//   reset      in  : asynchronous, active-high
//   msclk      in  : clock
//   raw        in  : raw button level, asynchronous to msclk
//   level      out : debounced level, registered
//   rise_pulse out : one-cycle pulse on each rising edge of level, registered
module btn_debounce #(
  parameter int DEB_CYCLES = 8
) (
  input  logic reset,
  input  logic msclk,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          samp_r;
  logic [CW-1:0] cnt_r;
  logic          level_r;
  logic          rise_r;
  logic          settled_s;

  // The sample has been equal for the full window once the count saturates.
  always_comb begin
    settled_s = 1'b0;
    if ((cnt_r == CMAX) && (sync2_r == samp_r)) begin
      settled_s = 1'b1;
    end else begin
      settled_s = 1'b0;
    end
  end

  // Synchronizer, stability counter, debounced level and rise detector.
  always_ff @(posedge msclk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      samp_r  <= 1'b0;
      cnt_r   <= '0;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      samp_r  <= sync2_r;
      // Any change of the synchronized sample restarts the count.
      if (sync2_r != samp_r) begin
        cnt_r <= '0;
      end else if (cnt_r != CMAX) begin
        cnt_r <= cnt_r + 1'b1;
      end
      if (settled_s) begin
        level_r <= samp_r;
      end
      // Pulse only on the 0->1 transition of level; a release gives nothing.
      rise_r <= settled_s & samp_r & ~level_r;
    end
  end

  assign level      = level_r;
  assign rise_pulse = rise_r;

endmodule

// File: rtl/scroll_addr_seq.sv
// Scroll address sequencer for the LED font ROM.
//   reset    in  : asynchronous, active-high
//   msclk    in  : clock
//   run      in  : 1 = auto-scroll, 0 = pause
//   dir      in  : 0 = increment, 1 = decrement
//   speed    in  : scroll period select, period = (speed+1)*BASE_DIV cycles
//   step_btn in  : raw single-step button (active-high), used while paused
//   radr     out : font ROM read address, registered
//   blank    out : LED blanking request, registered (high only after reset)
//   frame    out : one-cycle pulse registered together with a wrapped radr
module scroll_addr_seq
  import scroll_addr_seq_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int ADDR_MIN   = DEF_ADDR_MIN,
  parameter int ADDR_MAX   = DEF_ADDR_MAX,
  parameter int BASE_DIV   = 1,
  parameter int DEB_CYCLES = 8
) (
  input  logic          reset,
  input  logic          msclk,
  input  logic          run,
  input  logic          dir,
  input  logic [2:0]    speed,
  input  logic          step_btn,
  output logic [AW-1:0] radr,
  output logic          blank,
  output logic          frame
);

  localparam int PW = $clog2(8 * BASE_DIV) + 1;
  localparam logic [AW-1:0] AMIN = AW'(ADDR_MIN);
  localparam logic [AW-1:0] AMAX = AW'(ADDR_MAX);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [PW-1:0] pcnt_r;
  logic [PW-1:0] period_m1_s;
  logic          tick_s;
  logic          step_pulse_s;
  logic          step_level_s;
  logic          advance_s;
  logic          wrap_s;
  logic [AW-1:0] addr_nxt_s;
  logic [AW-1:0] radr_r;
  logic          blank_r;
  logic          blank_nxt_s;
  logic          frame_r;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_step_deb (
    .reset      (reset),
    .msclk      (msclk),
    .raw        (step_btn),
    .level      (step_level_s),
    .rise_pulse (step_pulse_s)
  );

  // FSM state register.
  always_ff @(posedge msclk or posedge reset) begin
    if (reset) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; INIT lasts exactly one cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT:  state_nxt_s = run ? ST_RUN : ST_PAUSE;
      ST_RUN:   state_nxt_s = run ? ST_RUN : ST_PAUSE;
      ST_PAUSE: state_nxt_s = run ? ST_RUN : ST_PAUSE;
      default:  state_nxt_s = ST_INIT;
    endcase
  end

  // FSM output logic: blanking only while (re)entering INIT.
  always_comb begin
    blank_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_INIT:  blank_nxt_s = 1'b1;
      ST_RUN:   blank_nxt_s = 1'b0;
      ST_PAUSE: blank_nxt_s = 1'b0;
      default:  blank_nxt_s = 1'b1;
    endcase
  end

  // Prescaler tick; ">=" lets a speed decrease mid-count fire on the next cycle.
  always_comb begin
    period_m1_s = PW'((int'(speed) + 1) * BASE_DIV - 1);
    if ((state_r == ST_RUN) && (pcnt_r >= period_m1_s)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Prescaler counter, held at zero outside RUN so entry into RUN waits a full period.
  always_ff @(posedge msclk or posedge reset) begin
    if (reset) begin
      pcnt_r <= '0;
    end else if ((state_r == ST_RUN) && !tick_s) begin
      pcnt_r <= pcnt_r + 1'b1;
    end else begin
      pcnt_r <= '0;
    end
  end

  // Advance selection by current state; steps outside PAUSE are dropped.
  always_comb begin
    advance_s = 1'b0;
    case (state_r)
      ST_RUN:   advance_s = tick_s;
      ST_PAUSE: advance_s = step_pulse_s;
      ST_INIT:  advance_s = 1'b0;
      default:  advance_s = 1'b0;
    endcase
  end

  // Next address with window wrap in either direction.
  always_comb begin
    addr_nxt_s = radr_r;
    wrap_s     = 1'b0;
    if (dir) begin
      if (radr_r == AMIN) begin
        addr_nxt_s = AMAX;
        wrap_s     = 1'b1;
      end else begin
        addr_nxt_s = radr_r - 1'b1;
      end
    end else begin
      if (radr_r == AMAX) begin
        addr_nxt_s = AMIN;
        wrap_s     = 1'b1;
      end else begin
        addr_nxt_s = radr_r + 1'b1;
      end
    end
  end

  // Output registers: address, blanking and wrap flag.
  always_ff @(posedge msclk or posedge reset) begin
    if (reset) begin
      radr_r  <= AMIN;
      blank_r <= 1'b1;
      frame_r <= 1'b0;
    end else begin
      blank_r <= blank_nxt_s;
      if (advance_s) begin
        radr_r  <= addr_nxt_s;
        frame_r <= wrap_s;
      end else begin
        frame_r <= 1'b0;
      end
    end
  end

  assign radr  = radr_r;
  assign blank = blank_r;
  assign frame = frame_r;

endmodule

// File: tb/tb_scroll_addr_seq.sv
module tb_scroll_addr_seq;

  typedef struct {
    logic [4:0] a;
    logic       f;
  } exp_t;

  logic       reset;
  logic       msclk;
  logic       run;
  logic       dir;
  logic [2:0] speed;
  logic       step_btn;
  logic [4:0] radr;
  logic       blank;
  logic       frame;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  scroll_addr_seq #(
    .AW(5), .ADDR_MIN(0), .ADDR_MAX(31), .BASE_DIV(1), .DEB_CYCLES(8)
  ) dut (
    .reset    (reset),
    .msclk    (msclk),
    .run      (run),
    .dir      (dir),
    .speed    (speed),
    .step_btn (step_btn),
    .radr     (radr),
    .blank    (blank),
    .frame    (frame)
  );

  initial msclk = 1'b0;
  always #5 msclk = ~msclk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input int a, input int f);
    exp_t e;
    e.a = 5'(a);
    e.f = 1'(f);
    exp_q.push_back(e);
  endtask

  // Move to 2 time units after the next rising edge.
  task automatic edge_t();
    @(posedge msclk);
    #2;
  endtask

  // Monitor: every address change is popped against the scoreboard.
  initial begin : monitor
    logic [4:0] prev;
    exp_t e;
    prev = 5'd0;
    forever begin
      @(negedge msclk);
      if (reset) begin
        prev = radr;
      end else if (radr != prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_advance: got radr %0d with nothing expected at %0t", radr, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_radr", int'(radr), int'(e.a));
          chk("sb_frame", int'(frame), int'(e.f));
        end
        prev = radr;
      end else begin
        chk("frame_idle", int'(frame), 0);
      end
    end
  end

  initial begin
    reset = 1'b0; run = 1'b1; speed = 3'd0; dir = 1'b0; step_btn = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("rst_radr", int'(radr), 0);
    chk("rst_blank", int'(blank), 1);
    chk("rst_frame", int'(frame), 0);

    // Free-run increment at full speed through one wrap.
    for (int i = 1; i < 32; i++) push(i, 0);
    push(0, 1);
    push(1, 0);
    edge_t(); edge_t();
    chk("held_blank", int'(blank), 1);
    reset = 1'b0;
    edge_t();
    chk("init_blank", int'(blank), 0);
    chk("init_radr", int'(radr), 0);
    repeat (32) edge_t();
    chk("wrap_up_radr", int'(radr), 0);
    chk("wrap_up_frame", int'(frame), 1);
    run = 1'b0;                 // next edge is still a tick
    edge_t();
    chk("last_tick_radr", int'(radr), 1);
    repeat (3) edge_t();
    chk("pause_hold1", int'(radr), 1);
    chk("q_empty1", exp_q.size(), 0);

    // One decrement at speed 0 to reach address 0, then pause.
    run = 1'b1; dir = 1'b1;
    push(0, 0);
    edge_t();                   // PAUSE -> RUN
    run = 1'b0;
    edge_t();
    chk("dec_to0", int'(radr), 0);
    edge_t(); edge_t();

    // Speed 3, decrement: wrap to 31 four cycles after entering RUN.
    speed = 3'd3; run = 1'b1;
    push(31, 1);
    push(30, 0);
    edge_t();                   // enter RUN
    repeat (3) edge_t();
    chk("spd3_wait", int'(radr), 0);
    edge_t();
    chk("wrap_dn_radr", int'(radr), 31);
    chk("wrap_dn_frame", int'(frame), 1);
    repeat (3) edge_t();
    chk("spd3_wait2", int'(radr), 31);
    edge_t();
    chk("spd3_next", int'(radr), 30);

    // Drop run on a tick cycle: one advance, then hold.
    repeat (3) edge_t();
    run = 1'b0;
    push(29, 0);
    edge_t();
    chk("drop_tick", int'(radr), 29);
    repeat (6) edge_t();
    chk("drop_hold", int'(radr), 29);
    run = 1'b1;
    push(28, 0);
    edge_t();                   // enter RUN
    repeat (3) edge_t();
    chk("rerun_wait", int'(radr), 29);
    edge_t();
    chk("rerun_adv", int'(radr), 28);
    run = 1'b0;
    edge_t();
    repeat (3) edge_t();
    chk("pause_hold2", int'(radr), 28);

    // Debounced single step in PAUSE, with initial bounce.
    dir = 1'b0;
    push(29, 0);
    step_btn = 1'b1; edge_t();
    step_btn = 1'b0; edge_t();
    step_btn = 1'b1;
    repeat (5) edge_t();
    chk("step_early", int'(radr), 28);
    repeat (15) edge_t();
    chk("step_adv", int'(radr), 29);
    step_btn = 1'b0;
    repeat (20) edge_t();
    chk("release_no_step", int'(radr), 29);
    chk("q_empty2", exp_q.size(), 0);

    // Button pressed while running: only ticks advance.
    run = 1'b1; speed = 3'd1; step_btn = 1'b1;
    push(30, 0); push(31, 0); push(0, 1);
    for (int i = 1; i < 8; i++) push(i, 0);
    edge_t();                   // enter RUN
    repeat (20) edge_t();
    chk("run_step_radr", int'(radr), 7);
    run = 1'b0; step_btn = 1'b0;
    repeat (21) edge_t();
    chk("run_step_hold", int'(radr), 7);
    chk("q_empty3", exp_q.size(), 0);

    // Reach 17 with pcnt=2, then assert reset between edges.
    run = 1'b1; speed = 3'd0;
    for (int i = 8; i < 18; i++) push(i, 0);
    edge_t();                   // enter RUN
    repeat (10) edge_t();
    speed = 3'd3;
    edge_t(); edge_t();
    chk("pre_reset_radr", int'(radr), 17);
    reset = 1'b1;
    #1;
    chk("async_radr", int'(radr), 0);
    chk("async_blank", int'(blank), 1);
    chk("async_frame", int'(frame), 0);
    chk("q_empty4", exp_q.size(), 0);
    #3 reset = 1'b0;
    edge_t();
    chk("rerelease_blank", int'(blank), 0);
    edge_t();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
